// File: rtl/md_pkg.sv
// md_pkg: E-stage MD op classes, MD unit opcodes and controller states.
package md_pkg;
  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } mdop_t;
  localparam logic [2:0] U_MULT  = 3'd0;
  localparam logic [2:0] U_MULTU = 3'd1;
  localparam logic [2:0] U_DIV   = 3'd2;
  localparam logic [2:0] U_DIVU  = 3'd3;
  localparam logic [2:0] U_MTHI  = 3'd4;
  localparam logic [2:0] U_MTLO  = 3'd5;
  localparam logic [2:0] U_NOP   = 3'd7;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
  function automatic logic [2:0] uop(input logic [3:0] op);
    return op == MD_MULT  ? U_MULT  :
           op == MD_MULTU ? U_MULTU :
           op == MD_DIV   ? U_DIV   :
           op == MD_DIVU  ? U_DIVU  :
           op == MD_MTHI  ? U_MTHI  :
           op == MD_MTLO  ? U_MTLO  : U_NOP;
  endfunction
endpackage

// File: rtl/md_lat_cnt.sv
// md_lat_cnt: loadable latency down-counter with zero flag; clear beats load beats decrement.
module md_lat_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] ld_val,
  input  logic             dec,
  input  logic             clr,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= (!reset_n || clr) ? '0 :
           load              ? ld_val :
           (dec && !zero)    ? cnt - 1'b1 : cnt;
  assign zero = cnt == '0;
endmodule

// File: rtl/md_sched.sv
// md_sched: MD unit issue/latency/stall controller; MD_CHECK_EN adds a sticky busy cross-check.
module md_sched
  import md_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        e_valid,
  input  logic [3:0]  e_mdop,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  input  logic        d_mduse,
  input  logic        flush,
  input  logic        md_busy,
  output logic        md_start,
  output logic [2:0]  md_op,
  output logic        md_write,
  output logic        md_sel,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic        md_abort,
  output logic        md_commit,
  output logic        busy,
  output logic        stall_d,
  output logic        div0,
  output logic        chk_err
);
  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_LAT - 1);
  state_t state, state_nx;
  logic issue, is_mul, is_div, rt_zero, zero;
  assign issue   = e_valid & ~flush & reset_n;
  assign is_mul  = e_mdop == MD_MULT || e_mdop == MD_MULTU;
  assign is_div  = e_mdop == MD_DIV || e_mdop == MD_DIVU;
  assign rt_zero = e_rt == '0;
  assign busy    = state == RUN;
  assign md_op   = uop(e_mdop);
  assign md_sel  = e_mdop == MD_MFHI;
  assign md_a    = e_rs;
  assign md_b    = e_rt;
  assign stall_d = d_mduse & (busy | md_start);
  always_ff @(posedge clk) state <= !reset_n ? IDLE : state_nx;
  // commit has priority over a flush landing on the final count
  always_comb begin
    md_start  = 1'b0;
    md_write  = 1'b0;
    md_commit = 1'b0;
    md_abort  = 1'b0;
    state_nx  = state;
    md_start  = !busy && issue && (is_mul || (is_div && !rt_zero));
    md_write  = !busy && issue && (e_mdop == MD_MTHI || e_mdop == MD_MTLO);
    md_commit = busy && zero && reset_n;
    md_abort  = busy && !zero && flush && reset_n;
    state_nx  = busy ? ((zero || flush) ? IDLE : RUN) : (md_start ? RUN : IDLE);
  end
  always_ff @(posedge clk) div0 <= !busy && issue && is_div && rt_zero;
  md_lat_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (md_start),
    .ld_val (is_div ? DIV_LD : MUL_LD),
    .dec    (busy),
    .clr    (md_abort),
    .zero   (zero)
  );
`ifdef MD_CHECK_EN
  always_ff @(posedge clk)
    chk_err <= !reset_n ? 1'b0 : chk_err | (busy & ~md_abort & ~md_busy);
`else
  logic unused_md_busy;
  assign unused_md_busy = md_busy;
  assign chk_err = 1'b0;
`endif
endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed self-checking bench for md_sched (default MULT_LAT=5, DIV_LAT=10).
module tb_md_sched;
  import md_pkg::*;
  logic        clk = 1'b0;
  logic        reset_n, e_valid, d_mduse, flush, md_busy, bus_drop;
  logic [3:0]  e_mdop;
  logic [31:0] e_rs, e_rt;
  logic        md_start, md_write, md_sel, md_abort, md_commit, busy, stall_d, div0, chk_err;
  logic [2:0]  md_op;
  logic [31:0] md_a, md_b;
  int checks = 0;
  int errors = 0;
  logic exp_chk;

  always #5 clk = ~clk;
  // emulated unit busy follows the controller unless deliberately dropped
  assign md_busy = busy & ~bus_drop;

  md_sched dut (
    .clk(clk), .reset_n(reset_n), .e_valid(e_valid), .e_mdop(e_mdop), .e_rs(e_rs), .e_rt(e_rt),
    .d_mduse(d_mduse), .flush(flush), .md_busy(md_busy), .md_start(md_start), .md_op(md_op),
    .md_write(md_write), .md_sel(md_sel), .md_a(md_a), .md_b(md_b), .md_abort(md_abort),
    .md_commit(md_commit), .busy(busy), .stall_d(stall_d), .div0(div0), .chk_err(chk_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic du, input logic fl);
    e_valid = v; e_mdop = op; e_rs = rs; e_rt = rt; d_mduse = du; flush = fl;
    #1;
  endtask

  initial begin
    reset_n = 1'b0; bus_drop = 1'b0;
    drive(1'b0, MD_NONE, 0, 0, 1'b0, 1'b0);
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_start", md_start, 0);
    chk("rst_commit", md_commit, 0);
    chk("rst_div0", div0, 0);
    chk("rst_chk", chk_err, 0);
    reset_n = 1'b1;
    tick();
    // MULT issue at T
    drive(1'b1, MD_MULT, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0);
    chk("mul_start", md_start, 1);
    chk("mul_op", md_op, U_MULT);
    chk("mul_a", md_a, 32'hFFFF_FFFF);
    chk("mul_b", md_b, 32'd2);
    chk("mul_stall_T", stall_d, 1);
    chk("mul_busy_T", busy, 0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      drive(1'b0, MD_NONE, 0, 0, 1'b1, 1'b0);
      chk($sformatf("mul_busy_%0d", k), busy, k <= 5);
      chk($sformatf("mul_start_%0d", k), md_start, 0);
      chk($sformatf("mul_commit_%0d", k), md_commit, k == 5);
      chk($sformatf("mul_stall_%0d", k), stall_d, k <= 5);
    end
    // DIVU by zero is suppressed
    tick();
    drive(1'b1, MD_DIVU, 32'd7, 32'd0, 1'b1, 1'b0);
    chk("dz_start", md_start, 0);
    chk("dz_stall", stall_d, 0);
    chk("dz_div0_T", div0, 0);
    tick();
    drive(1'b1, MD_MFLO, 0, 0, 1'b1, 1'b0);
    chk("dz_div0_T1", div0, 1);
    chk("dz_busy", busy, 0);
    chk("mflo_sel", md_sel, 0);
    chk("mflo_write", md_write, 0);
    chk("mflo_start", md_start, 0);
    tick();
    drive(1'b0, MD_NONE, 0, 0, 1'b0, 1'b0);
    chk("dz_div0_T2", div0, 0);
    // DIV flushed at T+4
    tick();
    drive(1'b1, MD_DIV, 32'd100, 32'd7, 1'b1, 1'b0);
    chk("div_start", md_start, 1);
    chk("div_op", md_op, U_DIV);
    for (int k = 1; k <= 12; k++) begin
      tick();
      drive(1'b0, MD_NONE, 0, 0, 1'b1, k == 4);
      chk($sformatf("div_busy_%0d", k), busy, k <= 4);
      chk($sformatf("div_abort_%0d", k), md_abort, k == 4);
      chk($sformatf("div_commit_%0d", k), md_commit, 0);
      chk($sformatf("div_stall_%0d", k), stall_d, k <= 4);
    end
    // MULT blocked by same-cycle flush
    tick();
    drive(1'b1, MD_MULT, 32'd3, 32'd4, 1'b0, 1'b1);
    chk("fl_start", md_start, 0);
    chk("fl_abort", md_abort, 0);
    tick();
    drive(1'b0, MD_NONE, 0, 0, 1'b0, 1'b0);
    chk("fl_busy", busy, 0);
    // MTHI then MFHI
    tick();
    drive(1'b1, MD_MTHI, 32'h1234, 0, 1'b0, 1'b0);
    chk("mthi_write", md_write, 1);
    chk("mthi_op", md_op, U_MTHI);
    chk("mthi_a", md_a, 32'h1234);
    chk("mthi_start", md_start, 0);
    tick();
    drive(1'b1, MD_MFHI, 0, 0, 1'b1, 1'b0);
    chk("mfhi_sel", md_sel, 1);
    chk("mfhi_write", md_write, 0);
    chk("mthi_busy", busy, 0);
    chk("mfhi_stall", stall_d, 0);
    // MULTU with unit busy dropped at T+2 and flush on the commit cycle
`ifdef MD_CHECK_EN
    exp_chk = 1'b1;
`else
    exp_chk = 1'b0;
`endif
    tick();
    drive(1'b1, MD_MULTU, 32'd5, 32'd6, 1'b0, 1'b0);
    chk("mu_op", md_op, U_MULTU);
    chk("mu_start", md_start, 1);
    for (int k = 1; k <= 6; k++) begin
      tick();
      bus_drop = (k == 2);
      drive(1'b0, MD_NONE, 0, 0, 1'b0, k == 5);
      chk($sformatf("mu_commit_%0d", k), md_commit, k == 5);
      chk($sformatf("mu_abort_%0d", k), md_abort, 0);
      if (k >= 3) chk($sformatf("mu_chk_%0d", k), chk_err, exp_chk);
      else chk($sformatf("mu_chk_%0d", k), chk_err, 0);
    end
    // reset mid-operation
    tick();
    drive(1'b1, MD_MULT, 32'd1, 32'd1, 1'b0, 1'b0);
    chk("rm_start", md_start, 1);
    tick();
    drive(1'b0, MD_NONE, 0, 0, 1'b0, 1'b0);
    chk("rm_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("rm_commit", md_commit, 0);
    chk("rm_abort", md_abort, 0);
    chk("rm_chk_hold", chk_err, exp_chk);
    tick();
    chk("rm_busy_after", busy, 0);
    chk("rm_chk_clr", chk_err, 0);
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("rm_idle_commit_%0d", k), md_commit, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
